// File: rtl/enm_hp_ctrl.sv
// Enemy wave controller: spawns four enemies, applies bullet damage with
// per-enemy invulnerability frames, and tracks kills and a saturating score.
module enm_hp_ctrl #(
  parameter logic [6:0] HP_MAX      = 7'd100,
  parameter int         IFRAMES     = 8,
  parameter int         SPAWN_DELAY = 32
) (
  input  logic       clk22,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] hit,
  input  logic [3:0] dmg,
  output logic [6:0] enmhp1,
  output logic [6:0] enmhp2,
  output logic [6:0] enmhp3,
  output logic [6:0] enmhp4,
  output logic [3:0] iframe,
  output logic [1:0] state,
  output logic [2:0] kills,
  output logic [9:0] score,
  output logic       wave_clear
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPAWN = 2'd1,
    ST_FIGHT = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [3:0]  IFR_LOAD   = 4'(IFRAMES);
  localparam logic [7:0]  SPAWN_LOAD = 8'(SPAWN_DELAY - 1);
  localparam logic [10:0] SCORE_MAX  = 11'd1000;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_spawn_cnt, w_spawn_nxt;
  logic [3:0][6:0] r_hp, w_hp_nxt;
  logic [3:0][3:0] r_ifc, w_ifc_nxt;
  logic [2:0]      r_kills, w_kills_nxt;
  logic [9:0]      r_score, w_score_nxt;
  logic            r_wave_clear, w_wave_clear_nxt;
  logic [3:0]      w_kill;
  logic [2:0]      w_nkill;
  logic [10:0]     w_score_sum;

  always_comb begin
    w_state_nxt      = r_state;
    w_spawn_nxt      = r_spawn_cnt;
    w_hp_nxt         = r_hp;
    w_ifc_nxt        = r_ifc;
    w_kills_nxt      = r_kills;
    w_score_nxt      = r_score;
    w_wave_clear_nxt = 1'b0;
    w_kill           = '0;
    w_nkill          = '0;
    w_score_sum      = '0;
    unique case (r_state)
      ST_IDLE, ST_CLEAR: begin
        if (start) begin
          w_state_nxt = ST_SPAWN;
          w_spawn_nxt = SPAWN_LOAD;
        end
      end
      ST_SPAWN: begin
        if (r_spawn_cnt == 8'd0) begin
          w_state_nxt = ST_FIGHT;
          w_hp_nxt    = {4{HP_MAX}};
          w_ifc_nxt   = '0;
          w_kills_nxt = '0;
        end else begin
          w_spawn_nxt = r_spawn_cnt - 8'd1;
        end
      end
      ST_FIGHT: begin
        // The counter value before this edge decides acceptance, so a counter
        // that is 1 now still blocks the hit even though it reaches 0 here.
        for (int i = 0; i < 4; i++) begin
          if (hit[i] && (r_hp[i] != 7'd0) && (r_ifc[i] == 4'd0)) begin
            w_hp_nxt[i]  = (r_hp[i] > {3'b000, dmg}) ? (r_hp[i] - {3'b000, dmg}) : 7'd0;
            w_ifc_nxt[i] = IFR_LOAD;
            w_kill[i]    = (r_hp[i] <= {3'b000, dmg});
          end else if (r_ifc[i] != 4'd0) begin
            w_ifc_nxt[i] = r_ifc[i] - 4'd1;
          end
        end
        w_nkill     = {2'b00, w_kill[0]} + {2'b00, w_kill[1]} +
                      {2'b00, w_kill[2]} + {2'b00, w_kill[3]};
        w_kills_nxt = r_kills + w_nkill;
        w_score_sum = {1'b0, r_score} + (11'(w_nkill) * 11'd10);
        w_score_nxt = (w_score_sum > SCORE_MAX) ? SCORE_MAX[9:0] : w_score_sum[9:0];
        if (w_hp_nxt == '0) begin
          w_state_nxt      = ST_CLEAR;
          w_wave_clear_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_spawn_cnt  <= '0;
      r_hp         <= '0;
      r_ifc        <= '0;
      r_kills      <= '0;
      r_score      <= '0;
      r_wave_clear <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_spawn_cnt  <= w_spawn_nxt;
      r_hp         <= w_hp_nxt;
      r_ifc        <= w_ifc_nxt;
      r_kills      <= w_kills_nxt;
      r_score      <= w_score_nxt;
      r_wave_clear <= w_wave_clear_nxt;
    end
  end

  always_comb begin
    iframe = '0;
    for (int i = 0; i < 4; i++) iframe[i] = (r_ifc[i] != 4'd0);
  end

  assign enmhp1     = r_hp[0];
  assign enmhp2     = r_hp[1];
  assign enmhp3     = r_hp[2];
  assign enmhp4     = r_hp[3];
  assign state      = r_state;
  assign kills      = r_kills;
  assign score      = r_score;
  assign wave_clear = r_wave_clear;

endmodule
